// File: rtl/register_writeback.sv
// Write-back stage and owner of the architectural register file: single writes, LM bursts, R7 redirect.
// Optional same-cycle write-through on the read ports: define WB_FORWARD_BYPASS_EN.
module register_writeback #(
    parameter int NREG = 8,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            hold,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [AW-1:0]   in_dest,
    input  logic [NREG-1:0] in_mask,
    input  logic [DW-1:0]   in_data,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [DW-1:0]   rd_data_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [DW-1:0]   rd_data_b,
    output logic            busy,
    output logic            pc_redirect,
    output logic [DW-1:0]   pc_value
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_next;
    logic [NREG-1:0] pend, pend_next;
    logic [DW-1:0]   regs [NREG];
    logic            fire, we;
    logic [AW-1:0]   waddr;

    function automatic logic [AW-1:0] lowest(input logic [NREG-1:0] m);
        logic [AW-1:0] k;
        k = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (m[i]) k = AW'(i);
        return k;
    endfunction

    // R0..R(N-2) reset to index+1; the PC register resets to zero
    function automatic logic [DW-1:0] rst_val(input logic [AW-1:0] a);
        return (int'(a) == NREG - 1) ? '0 : DW'(int'(a) + 1);
    endfunction

    assign in_ready = !hold && !flush;
    assign fire     = in_valid && in_ready;
    assign busy     = (state == BURST);

    always_comb begin
        state_next = state;
        pend_next  = pend;
        we         = 1'b0;
        waddr      = in_dest;
        case (state)
            IDLE: begin
                if (fire && in_op == 2'b01) begin
                    we = 1'b1;
                end else if (fire && in_op == 2'b10 && |in_mask) begin
                    we        = 1'b1;
                    waddr     = lowest(in_mask);
                    pend_next = in_mask & ~(NREG'(1) << waddr);
                    if (|pend_next) state_next = BURST;
                end
            end
            BURST: begin
                if (fire) begin
                    we        = 1'b1;
                    waddr     = lowest(pend);
                    pend_next = pend & ~(NREG'(1) << waddr);
                    if (pend_next == '0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            pend_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= rst_val(AW'(i));
            state       <= IDLE;
            pend        <= '0;
            pc_redirect <= 1'b0;
            pc_value    <= '0;
        end else begin
            state       <= state_next;
            pend        <= pend_next;
            pc_redirect <= we && (int'(waddr) == NREG - 1);
            if (we) regs[waddr] <= in_data;
            if (we && int'(waddr) == NREG - 1) pc_value <= in_data;
        end
    end

    // While reset is applied the stored file may not yet hold reset values, so show them directly
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef WB_FORWARD_BYPASS_EN
        if (we && waddr == rd_addr_a) rd_data_a = in_data;
        if (we && waddr == rd_addr_b) rd_data_b = in_data;
`endif
        if (!resetn) begin
            rd_data_a = rst_val(rd_addr_a);
            rd_data_b = rst_val(rd_addr_b);
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: reset, single writes, LM bursts with hold/flush/reset, R7 redirect.
module tb_register_writeback;

    localparam int NREG = 8;
    localparam int DW   = 16;
    localparam int AW   = 3;
`ifdef WB_FORWARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn, flush, hold, in_valid, in_ready;
    logic [1:0]      in_op;
    logic [AW-1:0]   in_dest, rd_addr_a, rd_addr_b;
    logic [NREG-1:0] in_mask;
    logic [DW-1:0]   in_data, rd_data_a, rd_data_b, pc_value;
    logic            busy, pc_redirect;

    int checks = 0;
    int errors = 0;

    register_writeback #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dest(in_dest), .in_mask(in_mask), .in_data(in_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .busy(busy), .pc_redirect(pc_redirect), .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // both read ports on the same register
    task automatic rd(input int addr, input logic [DW-1:0] exp);
        rd_addr_a = AW'(addr);
        rd_addr_b = AW'(addr);
        #1;
        chk($sformatf("rd_a R%0d", addr), 32'(rd_data_a), 32'(exp));
        chk($sformatf("rd_b R%0d", addr), 32'(rd_data_b), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [1:0] op, input int dest, input logic [7:0] mask, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_dest  = AW'(dest);
        in_mask  = mask;
        in_data  = d;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_mask  = '0;
        in_dest  = '0;
        in_data  = '0;
    endtask

    logic [DW-1:0] rstv [NREG];

    initial begin
        rstv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0};
        resetn = 1'b0; flush = 1'b0; hold = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        idle_in();
        @(negedge clk);
        rd(4, 16'd5);
        step(); step();
        resetn = 1'b1;
        step();

        // reset state
        for (int i = 0; i < NREG; i++) rd(i, rstv[i]);
        chk("busy_rst", 32'(busy), 32'd0);
        chk("pcr_rst", 32'(pc_redirect), 32'd0);
        chk("pcv_rst", 32'(pc_value), 32'd0);
        chk("ready_rst", 32'(in_ready), 32'd1);

        // single write, same cycle and next cycle view
        put(2'b01, 3, 8'h00, 16'hBEEF);
        rd_addr_a = 3'd3;
        #1 chk("sw_same", 32'(rd_data_a), BYPASS ? 32'hBEEF : 32'd4);
        step();
        idle_in();
        rd(3, 16'hBEEF);
        chk("sw_pcr", 32'(pc_redirect), 32'd0);

        // LM 1010_0110 with a 2-cycle hold on beat 2; op/mask ignored mid-burst
        put(2'b10, 0, 8'b1010_0110, 16'd11);
        step();
        chk("lm_busy1", 32'(busy), 32'd1);
        put(2'b00, 0, 8'h00, 16'd22);
        hold = 1'b1;
        #1 chk("lm_hold_ready", 32'(in_ready), 32'd0);
        step(); step();
        rd(2, 16'd3);
        chk("lm_hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        step();
        put(2'b01, 0, 8'h00, 16'd33);
        step();
        chk("lm_pcr_b3", 32'(pc_redirect), 32'd0);
        chk("lm_busy_b4", 32'(busy), 32'd1);
        put(2'b11, 0, 8'hFF, 16'd44);
        step();
        idle_in();
        chk("lm_busy_end", 32'(busy), 32'd0);
        chk("lm_pcr", 32'(pc_redirect), 32'd1);
        chk("lm_pcv", 32'(pc_value), 32'd44);
        step();
        chk("lm_pcr_off", 32'(pc_redirect), 32'd0);
        rd(1, 16'd11); rd(2, 16'd22); rd(5, 16'd33); rd(7, 16'd44);
        rd(0, 16'd1);  rd(6, 16'd7);

        // LM 0000_1111 flushed on beat 3
        put(2'b10, 0, 8'b0000_1111, 16'h00A0);
        step();
        in_data = 16'h00A1;
        step();
        in_data = 16'h00A2;
        flush = 1'b1;
        #1 chk("fl_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        idle_in();
        chk("fl_busy", 32'(busy), 32'd0);
        rd(0, 16'h00A0); rd(1, 16'h00A1); rd(2, 16'd22); rd(3, 16'hBEEF);
        step();
        chk("fl_busy2", 32'(busy), 32'd0);
        put(2'b01, 2, 8'h00, 16'h5555);
        step();
        idle_in();
        rd(2, 16'h5555); rd(3, 16'hBEEF);
        chk("fl_after_busy", 32'(busy), 32'd0);

        // NOP-like packets: mask 0, reserved op, op 00
        put(2'b10, 4, 8'h00, 16'hFFFF);
        #1 chk("nop_ready", 32'(in_ready), 32'd1);
        step();
        chk("nop_busy1", 32'(busy), 32'd0);
        put(2'b11, 4, 8'h10, 16'hFFFF);
        step();
        chk("nop_busy2", 32'(busy), 32'd0);
        put(2'b00, 4, 8'h10, 16'hFFFF);
        step();
        idle_in();
        rd(4, 16'd5); rd(0, 16'h00A0);
        chk("nop_pcr", 32'(pc_redirect), 32'd0);

        // back-to-back R7 writes: single, then single-bit LM
        put(2'b01, 7, 8'h00, 16'h0100);
        step();
        chk("r7a_pcr", 32'(pc_redirect), 32'd1);
        chk("r7a_pcv", 32'(pc_value), 32'h0100);
        put(2'b10, 0, 8'h80, 16'h0200);
        step();
        idle_in();
        chk("r7b_pcr", 32'(pc_redirect), 32'd1);
        chk("r7b_pcv", 32'(pc_value), 32'h0200);
        chk("r7b_busy", 32'(busy), 32'd0);
        step();
        chk("r7_pcr_off", 32'(pc_redirect), 32'd0);
        rd(7, 16'h0200);

        // reset after 2 of 4 beats, beats keep coming while reset is held
        put(2'b10, 0, 8'hF0, 16'h00D4);
        step();
        in_data = 16'h00D5;
        step();
        chk("rb_busy", 32'(busy), 32'd1);
        rd(5, 16'h00D5);
        resetn  = 1'b0;
        in_data = 16'hEEEE;
        rd(4, 16'd5);
        step();
        chk("rb_busy0", 32'(busy), 32'd0);
        chk("rb_pcr", 32'(pc_redirect), 32'd0);
        chk("rb_pcv", 32'(pc_value), 32'd0);
        step();
        rd(6, 16'd7);
        resetn = 1'b1;
        idle_in();
        rd_addr_a = 3'd6;
        #1 chk("rb_r6_stored", 32'(rd_data_a), 32'd7);
        step();
        for (int i = 0; i < NREG; i++) rd(i, rstv[i]);
        chk("rb_busy_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Write-back stage and register-file owner for the IITB RISC pipeline; the write-side counterpart of the register-read stage.
- Accepts write-back packets from the memory stage: single writes, and load-multiple bursts of one register per beat.
- Commits results to the 8x16 register file and serves two combinational read ports to the read stage.
- Raises a PC-redirect pulse whenever R7 (the PC) is written.

Parameters:
- NREG, 8, number of architectural registers; sets the width of in_mask.
- DW, 16, data width.
- AW, 3, register address width (log2 NREG).

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- flush  in  1  abort pending burst; no write in a cycle where flush=1
- hold  in  1  hazard-unit backpressure; forces in_ready low
- in_valid  in  1  packet/beat valid
- in_ready  out  1  stage can accept a packet/beat
- in_op  in  2  00 NOP, 01 single write, 10 multi write (LM), 11 reserved (treated as NOP)
- in_dest  in  AW  destination register for op 01
- in_mask  in  NREG  register mask for op 10; bit i set means write Ri
- in_data  in  DW  write data for the current write or beat
- rd_addr_a  in  AW  read port A address
- rd_data_a  out  DW  read port A data
- rd_addr_b  in  AW  read port B address
- rd_data_b  out  DW  read port B data
- busy  out  1  high while in BURST state
- pc_redirect  out  1  one-cycle pulse, the cycle after R7 is written
- pc_value  out  DW  value written to R7, valid with pc_redirect

Behaviour:
- Reset (resetn=0 at posedge clk) loads R0..R6 = 1,2,3,4,5,6,7 and R7 = 0.
  - Also resets: state to IDLE, pending mask to 0, busy=0, pc_redirect=0, pc_value=0.
  - Reset takes priority over flush, hold and any in-flight burst.
- in_ready = !hold && !flush.
- A transfer fires when in_valid && in_ready at posedge clk.
- State IDLE:
  - Fire with op 01: write in_data to R[in_dest] at that edge. Stay in IDLE.
  - Fire with op 10 and in_mask != 0: write in_data to R[k], where k is the lowest set bit of in_mask. Store in_mask with bit k cleared as the pending mask.
    - Pending mask nonzero: go to BURST.
    - Pending mask zero (single-bit mask): stay in IDLE.
  - Fire with op 10 and in_mask = 0, op 00, or op 11: no write, no state change.
- State BURST (busy=1):
  - in_op, in_dest and in_mask are ignored.
  - Each fire writes in_data to R[k], where k is the lowest set bit of the pending mask, then clears bit k.
  - Return to IDLE on the edge that clears the last pending bit.
  - Registers are written in ascending index order, one register per beat.
  - Beats with in_valid=0 or hold=1 stall the burst without loss.
- flush=1 at any edge (resetn=1): no register write; state goes to IDLE; pending mask cleared.
  - Registers already written earlier in the burst keep their new values.
- Writes to R7:
  - pc_redirect=1 in the following cycle only, with pc_value = the written data.
  - Back-to-back R7 writes give back-to-back pulses.
- Read ports are combinational from the register file.
  - Bypass behaviour depends on the optional feature below.
  - Reads return reset values while resetn=0 is applied.
- Latency: a write becomes visible in the stored register file one cycle after the fire edge.

Optional Feature:
- Macro: WB_FORWARD_BYPASS_EN.
- Defined: if a write fires this cycle with a target equal to rd_addr_a or rd_addr_b, that port returns in_data combinationally (same-cycle write-through).
  - Applies to single writes and burst beats.
  - Suppressed when flush=1 or resetn=0.
- Undefined: read ports return the stored value only; new data is visible from the next cycle.

Test Plan:
- Reset, then read all registers -> R0..R7 read 1,2,3,4,5,6,7,0; busy=0; pc_redirect=0.
- Single write op 01, dest 3, data 16'hBEEF; read port A addr 3 in the same cycle and the next ->
  - With bypass: BEEF in both cycles.
  - Without bypass: 4 then BEEF.
- LM with in_mask 8'b1010_0110, beat data 11,22,33,44 with hold=1 on the 2nd beat for 2 cycles ->
  - R1=11, R2=22, R5=33, R7=44.
  - busy high from after the first beat until the final beat.
  - pc_redirect pulses once with pc_value=44.
- LM with mask 8'b0000_1111, flush asserted on the 3rd beat ->
  - R0,R1 written; R2,R3 unchanged (3,4); state IDLE.
  - Next single write op 01 accepted normally.
- op 10 with mask 0, and op 11 -> no register changes; busy stays 0; in_ready stays 1.
- resetn=0 mid-burst after 2 of 4 beats -> all registers return to reset values, busy=0; with resetn held low, a further beat produces no write.
